// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared constants and FSM state encoding for the bit-serial adder.
// Contents: default operand width, state enum.
// Imported by the interface and the top-level engine.
package serial_adder_pkg;

  localparam int SA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for the bit-serial adder.
// Signals: in_valid/in_ready + op_a/op_b/sub/cin towards the engine; out_valid/out_ready +
// result/carry_out/overflow back; busy is a status flag. master = source/sink side, slave = engine.
interface serial_adder_if import serial_adder_pkg::*; #(
  parameter int WIDTH = SA_WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, op_a, op_b, sub, cin, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, cin, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, busy
  );

endinterface

// File: rtl/serial_adder_fa.sv
// serial_adder_fa: one-bit full-adder cell, used as the single slice of the serial engine.
// Latency: purely combinational. Backpressure: none.
// Ports: a_i, b_i, c_i operand/carry bits in; sum_o, carry_o out.
module serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, LSB first, one bit per clock through one full-adder slice.
// Latency: accept in cycle T -> out_valid from cycle T+WIDTH+1; initiation interval WIDTH+2, no overlap.
// Backpressure: result held in DONE until out_ready; in_ready stays low outside IDLE.
// Ports: clk, rst_n (async active-low), bus (serial_adder_if.slave: operands in, result/flags out).
module serial_adder import serial_adder_pkg::*; #(
  parameter  int WIDTH = SA_WIDTH_DEF,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  sa_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;     // carry into the MSB position
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;

  logic fa_sum;
  logic fa_co;
  logic in_ready;
  logic init_carry;
  logic last_bit;
  logic pre_msb_bit;

  serial_adder_fa u_slice (
    .a_i     (a_sh_q[0]),
    .b_i     (b_sh_q[0]),
    .c_i     (carry_q),
    .sum_o   (fa_sum),
    .carry_o (fa_co)
  );

  // Gated with rst_n so ready is low for the whole time reset is held.
  assign in_ready    = rst_n && (state_q == ST_IDLE);
  // Subtraction is A + ~B + 1, so the carry-in is forced high.
  assign init_carry  = bus.sub ? 1'b1 : bus.cin;
  assign last_bit    = (int'(cnt_q) == WIDTH - 1);
  assign pre_msb_bit = (WIDTH > 1) && (int'(cnt_q) == WIDTH - 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_msb_d = c_msb_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    co_d    = co_q;
    ov_d    = ov_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready) begin
          a_sh_d  = bus.op_a;
          b_sh_d  = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d = init_carry;
          // For WIDTH=1 the first bit is the MSB, so its carry-in is the initial carry.
          c_msb_d = init_carry;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Sum bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
        res_d   = (res_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (pre_msb_bit) begin
          c_msb_d = fa_co;
        end
        if (last_bit) begin
          co_d    = fa_co;
          ov_d    = c_msb_q ^ fa_co;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.result    = res_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ov_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized + directed check of serial_adder at WIDTH=8 and WIDTH=1
// against an arithmetic reference model (integer add/subtract, signed range test).
// One shared clock and reset; sel chooses which instance the stimulus tasks talk to.
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(W)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  bit             sel = 1'b0;  // 0: WIDTH=8 instance, 1: WIDTH=1 instance
  logic           in_valid = 1'b0;
  logic           sub = 1'b0;
  logic           cin = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   op_a = '0;
  logic [W-1:0]   op_b = '0;

  assign bus8.in_valid  = in_valid & ~sel;
  assign bus8.op_a      = op_a;
  assign bus8.op_b      = op_b;
  assign bus8.sub       = sub;
  assign bus8.cin       = cin;
  assign bus8.out_ready = out_ready & ~sel;
  assign bus1.in_valid  = in_valid & sel;
  assign bus1.op_a      = op_a[0:0];
  assign bus1.op_b      = op_b[0:0];
  assign bus1.sub       = sub;
  assign bus1.cin       = cin;
  assign bus1.out_ready = out_ready & sel;

  wire         s_in_ready  = sel ? bus1.in_ready  : bus8.in_ready;
  wire         s_out_valid = sel ? bus1.out_valid : bus8.out_valid;
  wire         s_busy      = sel ? bus1.busy      : bus8.busy;
  wire         s_co        = sel ? bus1.carry_out : bus8.carry_out;
  wire         s_ov        = sel ? bus1.overflow  : bus8.overflow;
  wire [W-1:0] s_res       = sel ? {{(W-1){1'b0}}, bus1.result} : bus8.result;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic on the operands, signed overflow from the
  // true signed result falling outside the w-bit two's-complement range.
  task automatic model(input int w, input longint a, input longint b, input bit s, input bit c,
                       output longint r, output bit co, output bit ov);
    longint m, sa, sb, full, sres;
    m    = longint'(1) << w;
    sa   = (a >= m / 2) ? a - m : a;
    sb   = (b >= m / 2) ? b - m : b;
    if (s) begin
      full = a - b;
      co   = (a >= b);
      sres = sa - sb;
    end else begin
      full = a + b + longint'(c);
      co   = (full >= m);
      sres = sa + sb + longint'(c);
    end
    r  = ((full % m) + m) % m;
    ov = (sres < -(m / 2)) || (sres >= m / 2);
  endtask

  task automatic run_op(input longint a, input longint b, input bit s, input bit c, input int hold);
    int     w;
    int     lat;
    longint r;
    bit     co, ov;
    logic [W-1:0] held;
    w = sel ? 1 : W;
    model(w, a, b, s, c, r, co, ov);
    @(negedge clk);
    op_a = W'(a); op_b = W'(b); sub = s; cin = c;
    in_valid = 1'b1; out_ready = 1'b0;
    chk("in_ready_idle", 64'(s_in_ready), 64'd1);
    @(posedge clk);
    #1;
    // Scramble inputs after accept: only the accept-edge values may matter.
    in_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("busy_run", 64'(s_busy), 64'(w > 0));
      if (s_out_valid) break;
    end
    chk("latency", 64'(lat), 64'(w + 1));
    chk("result", 64'(s_res), 64'(r));
    chk("carry_out", 64'(s_co), 64'(co));
    chk("overflow", 64'(s_ov), 64'(ov));
    held = s_res;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      @(negedge clk);
      chk("hold_out_valid", 64'(s_out_valid), 64'd1);
      chk("hold_in_ready", 64'(s_in_ready), 64'd0);
      chk("hold_result", 64'(s_res), 64'(held));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_out_valid", 64'(s_out_valid), 64'd0);
    chk("drain_in_ready", 64'(s_in_ready), 64'd1);
    chk("result_kept", 64'(s_res), 64'(held));
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(bus8.in_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(bus8.out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(bus8.busy), 64'd0);
    chk({tag, "_result"}, 64'(bus8.result), 64'd0);
    chk({tag, "_carry"}, 64'(bus8.carry_out), 64'd0);
    chk({tag, "_ovf"}, 64'(bus8.overflow), 64'd0);
    chk({tag, "_w1_result"}, 64'(bus1.result), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs [$];
    int cyc;
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(bus8.in_ready), 64'd1);

    // Directed cases, WIDTH=8
    sel = 1'b0;
    run_op(64'h3C, 64'h5A, 1'b0, 1'b0, 0);
    chk("dir_3c_5a", 64'(bus8.result), 64'h96);
    run_op(64'hFF, 64'h01, 1'b0, 1'b0, 0);
    run_op(64'h00, 64'h00, 1'b0, 1'b1, 0);
    run_op(64'h05, 64'h07, 1'b1, 1'b1, 0);
    chk("dir_05_07", 64'(bus8.result), 64'hFE);
    run_op(64'h80, 64'h01, 1'b1, 1'b0, 0);
    run_op(64'h7F, 64'h7F, 1'b0, 1'b0, 5);   // backpressure for 5 cycles

    // Back-to-back accepts with in_valid and out_ready held high
    @(negedge clk);
    op_a = 8'h11; op_b = 8'h22; sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0;
    while (hs.size() < 2 && cyc < 100) begin
      if (bus8.in_ready && in_valid) hs.push_back(cyc);
      if (hs.size() == 2) in_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("b2b_handshakes", 64'(hs.size()), 64'd2);
    if (hs.size() == 2) chk("initiation_interval", 64'(hs[1] - hs[0]), 64'(W + 2));
    repeat (W + 4) @(negedge clk);
    chk("b2b_result", 64'(bus8.result), 64'h33);
    chk("b2b_idle", 64'(bus8.in_ready), 64'd1);
    out_ready = 1'b0;

    // Reset while RUN at counter 3
    @(negedge clk);
    op_a = 8'h33; op_b = 8'h44; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midrun");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(64'h10, 64'h20, 1'b0, 1'b0, 0);
    chk("post_reset_add", 64'(bus8.result), 64'h30);

    // Random, WIDTH=8
    for (int i = 0; i < 40; i++)
      run_op(longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)),
             1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // WIDTH=1 instance
    sel = 1'b1;
    run_op(64'd1, 64'd1, 1'b0, 1'b1, 0);
    chk("w1_1p1c1", 64'(bus1.result), 64'd1);
    chk("w1_carry", 64'(bus1.carry_out), 64'd1);
    for (int i = 0; i < 12; i++)
      run_op(longint'($urandom_range(0, 1)), longint'($urandom_range(0, 1)),
             1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
